// File: rtl/tone_pkg.sv
// Shared types and constants for the colour-to-tone path (mapper and synthesizer).
package tone_pkg;

  localparam int FREQ_W = 10;

  // Note frequencies in Hz, shared with the colour-to-frequency mapper
  localparam int RED_FREQ    = 440;
  localparam int BLUE_FREQ   = 494;
  localparam int GREEN_FREQ  = 523;
  localparam int YELLOW_FREQ = 587;

  typedef enum logic [1:0] {IDLE, PLAY, DRAIN} tone_state_t;

endpackage

// File: rtl/tone_nco.sv
// Phase accumulator for the tone synthesizer: adds 2*freq per cycle and flags a
// half-period toggle whenever the sum reaches CLK_HZ, keeping the remainder.
module tone_nco #(
  parameter int CLK_HZ = 50_000_000,
  parameter int FREQ_W = tone_pkg::FREQ_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              run_i,
  input  logic              clear_i,
  input  logic [FREQ_W-1:0] freq_i,
  output logic              toggle_o
);

  localparam int AW = $clog2(CLK_HZ) + 1;
  localparam logic [AW-1:0] LIMIT = AW'(CLK_HZ);

  logic [AW-1:0] acc_q, acc_d, nxt;

  // Sum stays below 2*CLK_HZ, which fits in AW bits, so no carry is lost
  always_comb begin
    nxt      = acc_q + AW'({freq_i, 1'b0});
    toggle_o = run_i && (nxt >= LIMIT);
    acc_d    = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (run_i) begin
      acc_d = toggle_o ? (nxt - LIMIT) : nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/tone_synth.sv
// Square-wave tone synthesizer: starts, stops and retunes only on period boundaries.
// Optional minimum tone duration enabled by defining TONE_MIN_HOLD_EN.
module tone_synth #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int FREQ_W      = tone_pkg::FREQ_W,
  parameter int MIN_HOLD_MS = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sound,
  input  logic [FREQ_W-1:0] frequency,
  output logic              speaker,
  output logic              active,
  output logic              period_tick,
  output logic [FREQ_W-1:0] freq_q
);

  import tone_pkg::*;

  if (CLK_HZ < 2048 || MIN_HOLD_MS < 0) begin : g_param_check
    $error("tone_synth: CLK_HZ must be >= 2048 and MIN_HOLD_MS non-negative");
  end

  tone_state_t       state_q, state_d;
  logic              speaker_q, speaker_d;
  logic              tick_q, tick_d;
  logic              active_q, active_d;
  logic [FREQ_W-1:0] freq_d;
  logic              req, keep, clear, toggle;

  assign req = sound && (frequency != '0);

`ifdef TONE_MIN_HOLD_EN
  localparam longint HOLD_L = longint'(CLK_HZ) * MIN_HOLD_MS / 1000;
  localparam int     HW     = (HOLD_L < 2) ? 1 : $clog2(HOLD_L + 1);

  logic [HW-1:0] hold_q, hold_d;

  // Loaded when a tone starts; while nonzero the tone is kept alive regardless of req
  always_comb begin
    hold_d = hold_q;
    if (state_q == IDLE) begin
      hold_d = (state_d != IDLE) ? HW'(HOLD_L) : '0;
    end else if (hold_q != '0) begin
      hold_d = hold_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end

  assign keep = req || (hold_q != '0);
`else
  assign keep = req;
`endif

  tone_nco #(
    .CLK_HZ (CLK_HZ),
    .FREQ_W (FREQ_W)
  ) u_nco (
    .clk_i    (clk),
    .rst_i    (rst),
    .run_i    (state_q != IDLE),
    .clear_i  (clear),
    .freq_i   (freq_q),
    .toggle_o (toggle)
  );

  always_comb begin
    state_d   = state_q;
    speaker_d = speaker_q;
    tick_d    = 1'b0;
    freq_d    = freq_q;
    clear     = 1'b0;
    unique case (state_q)
      IDLE: begin
        clear     = 1'b1;
        speaker_d = 1'b0;
        freq_d    = '0;
        if (req) begin
          state_d   = PLAY;
          speaker_d = 1'b1;
          tick_d    = 1'b1;
          freq_d    = frequency;
        end
      end
      PLAY, DRAIN: begin
        state_d = keep ? PLAY : DRAIN;
        if (toggle && speaker_q) begin
          speaker_d = 1'b0;
        end else if (toggle) begin
          // Rising edge is the period boundary: the only place to retune or stop
          if (keep) begin
            state_d   = PLAY;
            speaker_d = 1'b1;
            tick_d    = 1'b1;
            if (req) begin
              freq_d = frequency;
            end
          end else begin
            state_d = IDLE;
            freq_d  = '0;
            clear   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign active_d = (state_d != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      speaker_q <= 1'b0;
      tick_q    <= 1'b0;
      active_q  <= 1'b0;
      freq_q    <= '0;
    end else begin
      state_q   <= state_d;
      speaker_q <= speaker_d;
      tick_q    <= tick_d;
      active_q  <= active_d;
      freq_q    <= freq_d;
    end
  end

  assign speaker     = speaker_q;
  assign period_tick = tick_q;
  assign active      = active_q;

endmodule
